// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (CPU)
// and the debug/dump port. The CPU normally wins. A starvation counter makes sure
// the debug port gets a slot. Read data comes back one cycle after the grant and
// goes to whichever port issued the read.
//
// rd_owner | meaning
// ---------+----------------------------------------------------------
// RD_NONE  | no read in flight; mem_rdata is ignored
// RD_CPU   | last cycle granted a CPU read; mem_rdata belongs to CPU
// RD_DBG   | last cycle granted a debug read; mem_rdata belongs to debug
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = 3
) (
  input  logic          clk,
  input  logic          pcclr,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DBG  = 2'd2
  } rd_owner_t;

  localparam logic [CNTW-1:0] LIMIT   = CNTW'(STARVE_LIMIT);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic            cpu_req;
  logic            cpu_gnt;
  logic            dbg_win;
  logic [CNTW-1:0] starve_cnt;
  rd_owner_t       rd_owner;

  // Grant decision: the CPU wins contention unless the debug port has waited long enough.
  always_comb begin
    cpu_req = cpu_re | cpu_we;
    dbg_win = dbg_req & (~cpu_req | (starve_cnt >= LIMIT));
    cpu_gnt = cpu_req & ~dbg_win;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign dbg_gnt   = dbg_win;

  // Memory port mux. With no grant the port is driven idle with zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = cpu_re;
    end else if (dbg_win) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
    end
  end

  // Starvation counter: counts cycles the debug port asks but loses. It saturates and clears on any other cycle.
  always_ff @(posedge clk or negedge pcclr) begin
    if (!pcclr) begin
      starve_cnt <= '0;
    end else if (dbg_req & ~dbg_win) begin
      if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Read-return FSM: remembers who owns next cycle's mem_rdata. rvalid flags are registered alongside it.
  always_ff @(posedge clk or negedge pcclr) begin
    if (!pcclr) begin
      rd_owner   <= RD_NONE;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else if (cpu_gnt & cpu_re) begin
      rd_owner   <= RD_CPU;
      cpu_rvalid <= 1'b1;
      dbg_rvalid <= 1'b0;
    end else if (dbg_win & ~dbg_we) begin
      rd_owner   <= RD_DBG;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b1;
    end else begin
      rd_owner   <= RD_NONE;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end
  end

  assign cpu_rdata = (rd_owner == RD_CPU) ? mem_rdata : '0;
  assign dbg_rdata = (rd_owner == RD_DBG) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. A behavioural model predicts grants, memory port
// contents and read returns, and checks them every cycle. Directed sequences
// pin the model with hand-computed values. Randomized traffic follows.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        pcclr = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we, mem_re;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        u1_cpu_stall, u1_cpu_rvalid, u1_dbg_gnt, u1_dbg_rvalid, u1_mem_we, u1_mem_re;
  logic [31:0] u1_cpu_rdata, u1_dbg_rdata, u1_mem_addr, u1_mem_wdata;
  logic [31:0] zero32 = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .CNTW(3)) u0 (
    .clk(clk), .pcclr(pcclr),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(0), .CNTW(3)) u1 (
    .clk(clk), .pcclr(pcclr),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(u1_cpu_stall), .cpu_rvalid(u1_cpu_rvalid), .cpu_rdata(u1_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(u1_dbg_gnt), .dbg_rvalid(u1_dbg_rvalid), .dbg_rdata(u1_dbg_rdata),
    .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_we(u1_mem_we), .mem_re(u1_mem_re),
    .mem_rdata(zero32)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(a * 3);
  endfunction

  function automatic bit dbg_wins(input bit creq, input bit dreq, input int cnt, input int lim);
    return dreq && (!creq || cnt >= lim);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory behind u0: synchronous read. Locations not yet written return init_val.
  bit          bm_w [64];
  logic [31:0] bm_d [64];
  always @(posedge clk) begin
    if (mem_we) begin
      bm_w[mem_addr[5:0]] <= 1'b1;
      bm_d[mem_addr[5:0]] <= mem_wdata;
    end
    if (mem_re)
      mem_rdata <= bm_w[mem_addr[5:0]] ? bm_d[mem_addr[5:0]] : init_val(int'(mem_addr[5:0]));
  end

  // Reference model. It tracks the starvation count, the expected read return, and its own copy of memory.
  int          m_cnt = 0;
  int          m_owner = 0;
  logic [31:0] m_data = '0;
  bit          rm_w [64];
  logic [31:0] rm_d [64];

  function automatic logic [31:0] ref_rd(input logic [5:0] a, input bit w, input logic [31:0] d);
    return w ? d : init_val(int'(a));
  endfunction

  always @(posedge clk or negedge pcclr) begin
    if (!pcclr) begin
      m_cnt   <= 0;
      m_owner <= 0;
      m_data  <= '0;
    end else begin
      if (dbg_req && !dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4))
        m_cnt <= (m_cnt < 7) ? m_cnt + 1 : 7;
      else
        m_cnt <= 0;
      if ((cpu_re | cpu_we) && !dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4)) begin
        m_owner <= cpu_re ? 1 : 0;
        m_data  <= cpu_re ? ref_rd(cpu_addr[5:0], rm_w[cpu_addr[5:0]], rm_d[cpu_addr[5:0]]) : '0;
        if (cpu_we) begin
          rm_w[cpu_addr[5:0]] <= 1'b1;
          rm_d[cpu_addr[5:0]] <= cpu_wdata;
        end
      end else if (dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4)) begin
        m_owner <= dbg_we ? 0 : 2;
        m_data  <= dbg_we ? '0 : ref_rd(dbg_addr[5:0], rm_w[dbg_addr[5:0]], rm_d[dbg_addr[5:0]]);
        if (dbg_we) begin
          rm_w[dbg_addr[5:0]] <= 1'b1;
          rm_d[dbg_addr[5:0]] <= dbg_wdata;
        end
      end else begin
        m_owner <= 0;
        m_data  <= '0;
      end
    end
  end

  // Per-cycle compare on the falling edge against the model.
  always @(negedge clk) begin
    check("stall", 32'(cpu_stall),
          32'((cpu_re | cpu_we) && dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4)));
    check("dbg_gnt", 32'(dbg_gnt), 32'(dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4)));
    check("mem_we", 32'(mem_we),
          dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4) ? 32'(dbg_we) : 32'(cpu_we));
    check("mem_re", 32'(mem_re),
          dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4) ? 32'(!dbg_we) : 32'(cpu_re));
    check("mem_addr", mem_addr,
          dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4) ? dbg_addr : ((cpu_re | cpu_we) ? cpu_addr : '0));
    check("mem_wdata", mem_wdata,
          dbg_wins(cpu_re | cpu_we, dbg_req, m_cnt, 4) ? dbg_wdata : ((cpu_re | cpu_we) ? cpu_wdata : '0));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_owner == 1));
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(m_owner == 2));
    check("cpu_rdata", cpu_rdata, (m_owner == 1) ? m_data : '0);
    check("dbg_rdata", dbg_rdata, (m_owner == 2) ? m_data : '0);
    check("u1_stall", 32'(u1_cpu_stall), 32'((cpu_re | cpu_we) && dbg_req));
    check("u1_dbg_gnt", 32'(u1_dbg_gnt), 32'(dbg_req));
  end

  task automatic idle();
    cpu_re = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned pat [10];
    logic [31:0] daddr [3];
    logic [31:0] dexp [3];

    // Reset behaviour: outputs idle during reset, and again after release.
    idle();
    @(negedge clk);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    #2 pcclr = 1'b1;
    next_cycle();
    cpu_re = 1'b1; cpu_addr = 32'h4;
    next_cycle();
    idle();
    @(negedge clk);
    check("pre_rst_rvalid", 32'(cpu_rvalid), 32'd1);
    #2 pcclr = 1'b0;
    #1;
    check("rst_async_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_async_rdata", cpu_rdata, 32'd0);
    #3 pcclr = 1'b1;
    // A read granted in the cycle just before reset must never return.
    next_cycle();
    cpu_re = 1'b1; cpu_addr = 32'h8;
    @(negedge clk);
    #2 pcclr = 1'b0;
    @(posedge clk);
    #4 idle();
    @(negedge clk);
    #2 pcclr = 1'b1;
    @(negedge clk);
    check("dropped_rvalid", 32'(cpu_rvalid), 32'd0);
    check("idle_mem_we", 32'(mem_we), 32'd0);
    check("idle_mem_re", 32'(mem_re), 32'd0);

    // CPU-only read of address 4.
    next_cycle();
    cpu_re = 1'b1; cpu_addr = 32'h4;
    @(negedge clk);
    check("t2_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t2_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t2_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t2_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

    // Back-to-back debug reads of addresses 1, 4 and 16.
    daddr[0] = 32'd1;  daddr[1] = 32'd4;         daddr[2] = 32'd16;
    dexp[0]  = 32'h1000_0003; dexp[1] = 32'hDEADBEEF; dexp[2] = 32'h1000_0030;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle();
      if (i < 3) begin
        dbg_req = 1'b1; dbg_addr = daddr[i];
      end
      @(negedge clk);
      if (i < 3) check("t4_gnt", 32'(dbg_gnt), 32'd1);
      if (i > 0) begin
        check("t4_rvalid", 32'(dbg_rvalid), 32'd1);
        check("t4_rdata", dbg_rdata, dexp[i-1]);
      end
    end

    // Sustained contention with a limit of 4: the debug port wins every fifth cycle.
    next_cycle();
    idle();
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      cpu_re = 1'b1; cpu_addr = 32'h8;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'hC;
      @(negedge clk);
      check("t3_dbg_gnt", 32'(dbg_gnt), pat[i]);
      check("t3_stall", 32'(cpu_stall), pat[i]);
    end

    // Contended writes: the CPU write goes through and the debug write waits.
    next_cycle();
    idle();
    next_cycle();
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h55;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hAA;
    @(negedge clk);
    check("t5_mem_we", 32'(mem_we), 32'd1);
    check("t5_mem_addr", mem_addr, 32'h10);
    check("t5_mem_wdata", mem_wdata, 32'h55);
    check("t5_dbg_gnt", 32'(dbg_gnt), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t5_no_rvalid", 32'(cpu_rvalid | dbg_rvalid), 32'd0);

    // With a limit of 0, debug wins all contention until it drops its request.
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      cpu_re = 1'b1; cpu_addr = 32'h18;
      dbg_req = (i < 6); dbg_we = 1'b0; dbg_addr = 32'h1C;
      @(negedge clk);
      check("t6_u1_stall", 32'(u1_cpu_stall), (i < 6) ? 32'd1 : 32'd0);
      check("t6_u1_gnt", 32'(u1_dbg_gnt), (i < 6) ? 32'd1 : 32'd0);
    end

    // Randomized traffic. A stalled CPU holds its request, and the occasional reset pulse lands mid-cycle.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (!cpu_stall) begin
        case ($urandom_range(0, 4))
          0, 1:    begin cpu_re = 1'b1; cpu_we = 1'b0; end
          2:       begin cpu_re = 1'b0; cpu_we = 1'b1; end
          default: begin cpu_re = 1'b0; cpu_we = 1'b0; end
        endcase
        cpu_addr  = 32'($urandom_range(0, 63));
        cpu_wdata = $urandom;
      end
      dbg_req   = ($urandom_range(0, 1) == 1);
      dbg_we    = ($urandom_range(0, 2) == 0);
      dbg_addr  = 32'($urandom_range(0, 63));
      dbg_wdata = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #1 pcclr = 1'b0;
        #5 pcclr = 1'b1;
      end
    end

    next_cycle();
    idle();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
